pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DATA_W, default 32: payload data width (ALU result, store data, target, etc. concatenated by the instantiator).
REQ-002 Parameter CTRL_W, default 8: control-field width (reg_write, mem_read, mem_write, branch, ...).
REQ-003 Parameter STALL_W, default 16: stall-counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous squash of all held entries.
REQ-007 clr_stats  input  1  synchronous clear of stall counter.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 in_data  input  DATA_W  upstream payload.
REQ-012 out_valid  output  1  head entry present.
REQ-013 out_ready  input  1  downstream accepts head entry.
REQ-014 out_ctrl  output  CTRL_W  head control bits; all-zero whenever out_valid=0.
REQ-015 out_data  output  DATA_W  head payload; don't-care when out_valid=0.
REQ-016 occupancy  output  2  entries held (0, 1 or 2).
REQ-017 stall_count  output  STALL_W  saturating count of back-pressure cycles.

Function
REQ-018 Storage: main register (head) plus one skid register, each with its own valid bit; FIFO order preserved.
REQ-019 Push = in_valid & in_ready; pop = out_valid & out_ready, both evaluated in the same cycle.
REQ-020 in_ready = not skid_valid, driven from a register (no combinational path from out_ready to in_ready).
REQ-021 out_valid = main_valid; out_data = main_data; out_ctrl = main_ctrl masked to zero when main_valid=0.
REQ-022 States: EMPTY (occ 0), ONE (main only), FULL (main+skid); occupancy reports the state.
REQ-023 EMPTY: push -> ONE, input loaded into main; no push -> EMPTY.
REQ-024 ONE: push & pop -> ONE, input replaces main; push only -> FULL, input into skid; pop only -> EMPTY; neither -> ONE, main holds.
REQ-025 FULL: pop -> ONE, skid moves to main; no pop -> FULL, both hold; push cannot occur (in_ready=0).
REQ-026 Latency: an entry pushed into EMPTY, or into ONE with a simultaneous pop, appears on out_* the next cycle; throughput one entry per cycle when out_ready stays 1.
REQ-027 flush=1: next state EMPTY regardless of push/pop; an entry offered in the flush cycle is dropped; in_ready=1 the cycle after flush.
REQ-028 Held entries never change while not popped (stable under back-pressure).
REQ-029 stall_count increments by 1 each cycle out_valid=1 & out_ready=0; saturates at 2^STALL_W-1, no wrap.
REQ-030 clr_stats=1 zeroes stall_count next cycle, overriding increment; flush does not affect stall_count.

Reset
REQ-031 reset=1 immediately (asynchronously) forces: main_valid=0, skid_valid=0, in_ready=1, out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_count=0.
REQ-032 Reset asserted mid-operation discards all held entries; no entry is emitted after reset release until a new push.
REQ-033 First push accepted on the first rising edge with reset=0.

Verification
REQ-034 Streaming: out_ready=1, push data 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 on the following 8 consecutive cycles, occupancy stays 1, stall_count=0.
REQ-035 Back-pressure: push 0xA, 0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA held; raise out_ready -> 0xA then 0xB in order, in_ready=1 one cycle after first pop.
REQ-036 Flush: FULL with ctrl=0x0F on both entries, flush=1 while in_valid=1 with 0xC -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0; 0xC never appears.
REQ-037 Saturation: STALL_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_count=15; clr_stats=1 together with a stall cycle -> stall_count=0.
REQ-038 Async reset: FULL state, assert reset between clock edges -> outputs reach reset values before the next edge; after release, out_valid stays 0 until a push.
REQ-039 Random: random in_valid/out_ready/flush 10k cycles vs. queue model -> no loss, duplication or reordering outside flush; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid-buffered pipeline stage with stall statistics
module pipe_stage_skid #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 8,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               clr_stats,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         occupancy,
  output logic [STALL_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic                in_ready_q, in_ready_d;
  logic [STALL_W-1:0]  stall_count_q, stall_count_d;

  logic main_valid;
  logic push;
  logic pop;

  assign main_valid = (state_q != ST_EMPTY);
  assign push       = in_valid & in_ready_q;
  assign pop        = main_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d     = ST_ONE;
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_data_d = in_data;
          main_ctrl_d = in_ctrl;
        end else if (push) begin
          state_d     = ST_FULL;
          skid_data_d = in_data;
          skid_ctrl_d = in_ctrl;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can move the state
        if (pop) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_ctrl_d = skid_ctrl_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
  end

  // Registered ready: derived from next state so out_ready never reaches in_ready combinationally
  always_comb begin
    in_ready_d = (state_d != ST_FULL);
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (clr_stats) begin
      stall_count_d = '0;
    end else if (main_valid && !out_ready && (stall_count_q != {STALL_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      main_data_q   <= '0;
      main_ctrl_q   <= '0;
      skid_data_q   <= '0;
      skid_ctrl_q   <= '0;
      in_ready_q    <= 1'b1;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      main_data_q   <= main_data_d;
      main_ctrl_q   <= main_ctrl_d;
      skid_data_q   <= skid_data_d;
      skid_ctrl_q   <= skid_ctrl_d;
      in_ready_q    <= in_ready_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid;
  assign out_data    = main_data_q;
  assign out_ctrl    = main_valid ? main_ctrl_q : '0;
  assign occupancy   = state_q;
  assign stall_count = stall_count_q;

endmodule
